// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: loader side; slave: stream source / memory side.
interface im_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] im_add;
  logic [31:0] im_data;
  logic        im_en;
  logic        im_rd_wr;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output im_add,
    output im_data,
    output im_en,
    output im_rd_wr
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  im_add,
    input  im_data,
    input  im_en,
    input  im_rd_wr
  );
endinterface

// File: rtl/im_loader.sv
// Boot loader: header count, big-endian data words, trailing checksum.
// Writes each word to instruction memory and releases the CPU on success.
module im_loader #(
  parameter int          NMEM      = 20,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  im_loader_if.master  bus,
  output logic         cpu_rst,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] NMAX = 32'(NMEM);

  state_t      state;
  logic [1:0]  bcnt;
  logic [23:0] shreg;
  logic [31:0] count;
  logic [31:0] k;
  logic [31:0] csum;
  logic        ready_q;
  logic        en_q;
  logic        rdwr_q;
  logic [31:0] add_q;
  logic [31:0] data_q;

  logic [31:0] word;
  logic        take;
  logic        last;
  logic [31:0] k_nxt;

  assign word  = {shreg, bus.in_data};
  assign take  = bus.in_valid && ready_q;
  assign last  = take && (bcnt == 2'd3);
  assign k_nxt = k + 32'd1;

  assign bus.in_ready = ready_q;
  assign bus.im_en    = en_q;
  assign bus.im_rd_wr = rdwr_q;
  assign bus.im_add   = add_q;
  assign bus.im_data  = data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bcnt    <= 2'd0;
      shreg   <= 24'd0;
      count   <= 32'd0;
      k       <= 32'd0;
      csum    <= 32'd0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      rdwr_q  <= 1'b0;
      add_q   <= 32'd0;
      data_q  <= 32'd0;
      cpu_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      // ready_q is only high in HDR/DATA/CHK, so take implies one of those
      if (take) begin
        shreg <= word[23:0];
        bcnt  <= bcnt + 2'd1;
      end
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state   <= HDR;
            bcnt    <= 2'd0;
            count   <= 32'd0;
            k       <= 32'd0;
            csum    <= 32'd0;
            ready_q <= 1'b1;
            cpu_rst <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
          end
        end
        HDR: begin
          if (last) begin
            if (word != 32'd0 && word <= NMAX) begin
              count <= word;
              state <= DATA;
            end else begin
              state   <= ERR;
              ready_q <= 1'b0;
              busy    <= 1'b0;
              error   <= 1'b1;
            end
          end
        end
        DATA: begin
          if (last) begin
            state   <= WRITE;
            ready_q <= 1'b0;
            en_q    <= 1'b1;
            rdwr_q  <= 1'b1;
            data_q  <= word;
            add_q   <= BASE_ADDR + {k[29:0], 2'b00};
          end
        end
        WRITE: begin
          en_q    <= 1'b0;
          rdwr_q  <= 1'b0;
          ready_q <= 1'b1;
          csum    <= csum + data_q;
          k       <= k_nxt;
          state   <= (k_nxt < count) ? DATA : CHK;
        end
        CHK: begin
          if (last) begin
            ready_q <= 1'b0;
            busy    <= 1'b0;
            if (word == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomised scoreboard bench for im_loader.
// Expected writes are queued by the load task; a negedge monitor pops them.
module tb_im_loader;
  localparam int          NMEM = 20;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_rst;
  logic busy;
  logic done;
  logic error;

  im_loader_if bus();

  im_loader #(
    .NMEM(NMEM),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] add;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] wq[$];
  int          checks = 0;
  int          errors = 0;
  int          n_wr = 0;
  logic [31:0] last_add = 32'd0;
  bit          jitter = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.im_en === 1'b1) begin
      n_wr++;
      last_add = bus.im_add;
      chk("wr_in_ready", 32'(bus.in_ready), 32'd0);
      chk("wr_rd_wr", 32'(bus.im_rd_wr), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got add %h data %h expected none",
                 bus.im_add, bus.im_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_add", bus.im_add, mon_e.add);
        chk("wr_data", bus.im_data, mon_e.data);
      end
    end else begin
      chk("idle_rd_wr", 32'(bus.im_rd_wr), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    bit acc;
    if (jitter) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      acc = bus.in_ready;
      tick();
      if (acc) break;
      g++;
      if (g > 50) begin
        checks++;
        errors++;
        $display("FAIL byte_stall: got no accept expected accept of %h", b);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_im_en", 32'(bus.im_en), 32'd0);
    chk("rst_im_rd_wr", 32'(bus.im_rd_wr), 32'd0);
    chk("rst_im_add", bus.im_add, 32'd0);
    chk("rst_im_data", bus.im_data, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
  endtask

  function automatic logic [31:0] wsum();
    logic [31:0] s = 32'd0;
    foreach (wq[i]) s += wq[i];
    return s;
  endfunction

  // Model: a count in 1..NMEM yields one write per word at BASE+4i;
  // success iff the trailer equals the 32-bit wrapping sum of the words.
  task automatic load(input logic [31:0] cnt, input logic [31:0] cs,
                      input int abort_at, input bit start_mid);
    int  n0 = n_wr;
    int  nexp = 0;
    bit  ok;
    bit  exp_done;
    wr_t e;
    ok = (cnt >= 32'd1) && (cnt <= 32'(NMEM));
    if (ok) begin
      nexp = (abort_at > 0) ? abort_at : int'(cnt);
      for (int i = 0; i < nexp; i++) begin
        e.add  = BASE + 32'(4 * i);
        e.data = wq[i];
        exp_q.push_back(e);
      end
    end
    exp_done = ok && (wsum() == cs);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("start_done", 32'(done), 32'd0);
    chk("start_error", 32'(error), 32'd0);
    send_word(cnt);
    if (!ok) begin
      repeat (3) tick();
      chk("badcnt_error", 32'(error), 32'd1);
      chk("badcnt_done", 32'(done), 32'd0);
      chk("badcnt_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("badcnt_busy", 32'(busy), 32'd0);
      chk("badcnt_writes", 32'(n_wr - n0), 32'd0);
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      send_word(wq[i]);
      if (start_mid && i == 0) begin
        tick();
        pulse_start();
        chk("mid_start_busy", 32'(busy), 32'd1);
      end
      if (abort_at == i + 1) begin
        rst = 1'b0;
        tick();
        check_reset();
        rst = 1'b1;
        repeat (2) tick();
        chk("abort_writes", 32'(n_wr - n0), 32'(abort_at));
        chk("abort_queue", 32'(exp_q.size()), 32'd0);
        return;
      end
    end
    send_word(cs);
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_error", 32'(error), 32'(!exp_done));
    chk("end_cpu_rst", 32'(cpu_rst), 32'(exp_done));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_writes", 32'(n_wr - n0), cnt);
    chk("end_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();
    chk("hold_done", 32'(done), 32'(exp_done));
    chk("hold_cpu_rst", 32'(cpu_rst), 32'(exp_done));
  endtask

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom());
  endtask

  initial begin
    int c;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) tick();
    check_reset();
    rst = 1'b1;
    tick();

    wq = '{32'h20010005, 32'h00221820};
    load(32'd2, 32'h20231825, 0, 1'b0);
    chk("ex_last_add", last_add, BASE + 32'h4);

    load(32'd2, 32'h00000000, 0, 1'b0);

    load(32'd0, 32'h0, 0, 1'b0);
    load(32'd21, 32'h0, 0, 1'b0);

    jitter = 1'b1;
    rand_words(20);
    load(32'd20, wsum(), 0, 1'b0);
    chk("max_last_add", last_add, BASE + 32'h4C);
    jitter = 1'b0;

    rand_words(3);
    load(32'd3, wsum(), 0, 1'b1);

    rand_words(4);
    load(32'd4, wsum(), 0, 1'b0);

    rand_words(5);
    load(32'd5, wsum(), 3, 1'b0);

    c = $urandom_range(1, 6);
    rand_words(c);
    load(32'(c), wsum(), 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      jitter = bit'($urandom_range(0, 1));
      c = $urandom_range(0, NMEM + 2);
      rand_words((c >= 1 && c <= NMEM) ? c : 0);
      load(32'(c), ($urandom_range(0, 1) == 1) ? wsum() : $urandom(),
           0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter NMEM, default 20: maximum number of instruction words the loader may write.
REQ-002 Parameter BASE_ADDR, default 32'h0: byte address of the first instruction word written.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE or ERR.
REQ-006 in_valid  input  1  byte-stream source has a valid byte.
REQ-007 in_data  input  8  stream byte.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 im_add  output  32  instruction-memory byte address.
REQ-010 im_data  output  32  instruction word to write.
REQ-011 im_en  output  1  instruction-memory access strobe, one cycle per word.
REQ-012 im_rd_wr  output  1  1 = write, 0 = read; always 1 whenever im_en is 1.
REQ-013 cpu_rst  output  1  active-low CPU reset; 0 holds the CPU in reset.
REQ-014 busy  output  1  load in progress (HDR, DATA, WRITE or CHK).
REQ-015 done  output  1  load completed, checksum matched.
REQ-016 error  output  1  load aborted: bad count or checksum mismatch.

Function
REQ-017 A byte transfers only when in_valid and in_ready are both 1 on a rising edge.
REQ-018 Bytes assemble into words big-endian: the first byte accepted becomes bits [31:24]; a 2-bit byte counter wraps 3->0 after each word.
REQ-019 The FSM states are IDLE, HDR, DATA, WRITE, CHK, DONE and ERR.
REQ-020 IDLE/DONE/ERR with start=1 -> HDR next cycle; word count, address, checksum and byte counter clear; cpu_rst=0, done=0, error=0.
REQ-021 HDR: in_ready=1; after the 4th byte, if the assembled word is in 1..NMEM -> DATA with count latched, else -> ERR.
REQ-022 DATA: in_ready=1; after the 4th byte -> WRITE with the word held in im_data.
REQ-023 WRITE, exactly one cycle: in_ready=0, im_en=1, im_rd_wr=1, im_add=BASE_ADDR+4*k (k = 0-based word index).
REQ-024 WRITE: the checksum accumulates im_data (sum mod 2^32); k increments; the next state is DATA if k+1 < count, else CHK.
REQ-025 CHK: in_ready=1; after the 4th byte -> DONE if the word equals the checksum, else -> ERR.
REQ-026 DONE: cpu_rst=1 and done=1 hold until start or reset.
REQ-027 ERR: error=1 and cpu_rst=0 hold until start or reset.
REQ-028 cpu_rst is 0 in every state except DONE.
REQ-029 A write occurs on the cycle after the 4th byte of a data word is accepted (latency 1); the minimum is 5 cycles per word.
REQ-030 When im_en=0: im_rd_wr=0; im_add and im_data hold their last values.
REQ-031 start while busy=1 is ignored.
REQ-032 in_valid outside HDR/DATA/CHK is not accepted (in_ready=0); in_valid gaps stall the FSM with no state change.
REQ-033 Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
REQ-034 A count of exactly NMEM is legal; NMEM+1 or 0 -> ERR with no im_en pulse.

Reset
REQ-035 With rst=0 at a clock edge: state=IDLE; in_ready=0, im_en=0, im_rd_wr=0, im_add=0, im_data=0, cpu_rst=0, busy=0, done=0, error=0; counters and checksum = 0.
REQ-036 Reset mid-load aborts with no further im_en pulse; words already written are not re-issued or rolled back.

Verification
REQ-037 Load count=2, words 0x20010005, 0x00221820, checksum 0x20231825 -> writes at addresses 0x0 and 0x4, then done=1 and cpu_rst=1.
REQ-038 Same load with checksum 0x00000000 -> two writes, then error=1, cpu_rst=0, done=0.
REQ-039 Count=0 and count=21 (NMEM=20) -> ERR; no im_en pulse.
REQ-040 Count=20 with in_valid toggled randomly -> exactly 20 im_en pulses, last im_add=0x4C, in_ready=0 during every WRITE cycle.
REQ-041 rst=0 after the 3rd write of a 5-word load -> all outputs at reset values next cycle; a new start then reloads from BASE_ADDR.
REQ-042 start pulsed during DATA -> no effect; start in DONE -> cpu_rst=0 next cycle and HDR entered.
